// File: rtl/ldpc_sparse_pkg.sv
// Shared definitions for the LDPC sparse B-transpose multiplier: FSM states,
// block length, tap indices and rotate amount.
package ldpc_sparse_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_PING,
    ST_PONG,
    ST_WAIT_FOR_PING,
    ST_WAIT_FOR_PONG
  } states_t;

  localparam int BLOCK_LEN = 11;
  localparam int ROT_AMT   = 7;

  localparam logic [3:0] TAP_LOAD = 4'd0;
  localparam logic [3:0] TAP_XOR  = 4'd5;
  localparam logic [3:0] LAST_IDX = 4'(BLOCK_LEN - 1);

endpackage

// File: rtl/ldpc_bt_accum.sv
// One accumulation buffer of the ping/pong pair: load or XOR a word in,
// and track whether the buffer holds a finished result.
module ldpc_bt_accum #(
  parameter int WIDTH = 96
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             load,
  input  logic             xor_en,
  input  logic [WIDTH-1:0] word,
  input  logic             set_full,
  input  logic             clear_full,
  output logic [WIDTH-1:0] acc,
  output logic             full
);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      acc  <= '0;
      full <= 1'b0;
    end else begin
      if (load) begin
        acc <= word;
      end else if (xor_en) begin
        acc <= acc ^ word;
      end
      // A buffer is never filled and drained in the same cycle, so set wins.
      if (set_full) begin
        full <= 1'b1;
      end else if (clear_full) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ldpc_sparse_mult_by_bt.sv
// Transpose of the sparse B multiply: 11-word blocks in, rotr7(w0)^w5 out,
// double-buffered. Optional sticky zero check under LDPC_SPARSE_BT_ZERO_CHECK_EN.
module ldpc_sparse_mult_by_bt
  import ldpc_sparse_pkg::*;
#(
  parameter int WIDTH = 96
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_input_data,
  input  logic             i_input_valid,
  output logic             o_input_ready,
  output logic [WIDTH-1:0] o_output_data,
  output logic             o_output_valid,
  input  logic             i_output_ready
`ifdef LDPC_SPARSE_BT_ZERO_CHECK_EN
  ,output logic            o_zero_error
`endif
);

  states_t fill_state, fill_next;
  states_t rd_state, rd_next;
  logic [3:0] idx;

  logic             accept;
  logic             last_beat;
  logic             out_hs;
  logic [WIDTH-1:0] rotated;
  logic [WIDTH-1:0] acc_word;
  logic             tap_load, tap_xor;

  logic             ping_load, ping_xor, ping_set, ping_clear, ping_full;
  logic             pong_load, pong_xor, pong_set, pong_clear, pong_full;
  logic [WIDTH-1:0] ping_acc, pong_acc;
  logic             ping_avail, pong_avail;

  assign o_input_ready  = (fill_state == ST_PING) || (fill_state == ST_PONG);
  assign o_output_valid = (rd_state == ST_PING) || (rd_state == ST_PONG);

  assign accept    = i_input_valid && o_input_ready;
  assign out_hs    = o_output_valid && i_output_ready;
  assign last_beat = accept && (idx == LAST_IDX);
  assign tap_load  = accept && (idx == TAP_LOAD);
  assign tap_xor   = accept && (idx == TAP_XOR);

  assign rotated  = {i_input_data[ROT_AMT-1:0], i_input_data[WIDTH-1:ROT_AMT]};
  assign acc_word = (idx == TAP_LOAD) ? rotated : i_input_data;

  assign ping_load  = tap_load && (fill_state == ST_PING);
  assign ping_xor   = tap_xor && (fill_state == ST_PING);
  assign ping_set   = last_beat && (fill_state == ST_PING);
  assign ping_clear = out_hs && (rd_state == ST_PING);
  assign pong_load  = tap_load && (fill_state == ST_PONG);
  assign pong_xor   = tap_xor && (fill_state == ST_PONG);
  assign pong_set   = last_beat && (fill_state == ST_PONG);
  assign pong_clear = out_hs && (rd_state == ST_PONG);

  // Looking at the set strobe lets readout present a block one cycle after beat 10.
  assign ping_avail = ping_full || ping_set;
  assign pong_avail = pong_full || pong_set;

  ldpc_bt_accum #(.WIDTH(WIDTH)) u_ping (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .load       (ping_load),
    .xor_en     (ping_xor),
    .word       (acc_word),
    .set_full   (ping_set),
    .clear_full (ping_clear),
    .acc        (ping_acc),
    .full       (ping_full)
  );

  ldpc_bt_accum #(.WIDTH(WIDTH)) u_pong (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .load       (pong_load),
    .xor_en     (pong_xor),
    .word       (acc_word),
    .set_full   (pong_set),
    .clear_full (pong_clear),
    .acc        (pong_acc),
    .full       (pong_full)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      fill_state <= ST_INIT;
      rd_state   <= ST_INIT;
      idx        <= '0;
    end else begin
      fill_state <= fill_next;
      rd_state   <= rd_next;
      if (accept) begin
        idx <= (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
      end
    end
  end

  always_comb begin
    fill_next = fill_state;
    case (fill_state)
      ST_INIT:          fill_next = ST_PING;
      ST_PING:          if (last_beat) fill_next = pong_full ? ST_WAIT_FOR_PONG : ST_PONG;
      ST_PONG:          if (last_beat) fill_next = ping_full ? ST_WAIT_FOR_PING : ST_PING;
      ST_WAIT_FOR_PING: if (!ping_full) fill_next = ST_PING;
      ST_WAIT_FOR_PONG: if (!pong_full) fill_next = ST_PONG;
      default:          fill_next = ST_INIT;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      ST_INIT:          rd_next = ST_WAIT_FOR_PING;
      ST_WAIT_FOR_PING: if (ping_avail) rd_next = ST_PING;
      ST_WAIT_FOR_PONG: if (pong_avail) rd_next = ST_PONG;
      ST_PING:          if (out_hs) rd_next = pong_avail ? ST_PONG : ST_WAIT_FOR_PONG;
      ST_PONG:          if (out_hs) rd_next = ping_avail ? ST_PING : ST_WAIT_FOR_PING;
      default:          rd_next = ST_INIT;
    endcase
  end

  always_comb begin
    o_output_data = '0;
    case (rd_state)
      ST_PING: o_output_data = ping_acc;
      ST_PONG: o_output_data = pong_acc;
      default: o_output_data = '0;
    endcase
  end

`ifdef LDPC_SPARSE_BT_ZERO_CHECK_EN
  // Words off the taps should be zero in a well-formed codeword block.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_zero_error <= 1'b0;
    end else if (accept && (idx != TAP_LOAD) && (idx != TAP_XOR) && (|i_input_data)) begin
      o_zero_error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ldpc_sparse_mult_by_bt.sv
// Scoreboard bench for ldpc_sparse_mult_by_bt: driver pushes expected results,
// an independent monitor pops them on every output handshake.
module tb_ldpc_sparse_mult_by_bt;

  localparam int W = 96;

  logic         i_clock = 1'b0;
  logic         i_reset = 1'b1;
  logic [W-1:0] i_input_data = '0;
  logic         i_input_valid = 1'b0;
  logic         o_input_ready;
  logic [W-1:0] o_output_data;
  logic         o_output_valid;
  logic         i_output_ready = 1'b0;
`ifdef LDPC_SPARSE_BT_ZERO_CHECK_EN
  logic         o_zero_error;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int ready_mode = 0;
  int watch_beat = -1;
  logic [W-1:0] exp_q[$];

  ldpc_sparse_mult_by_bt #(.WIDTH(W)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_input_data   (i_input_data),
    .i_input_valid  (i_input_valid),
    .o_input_ready  (o_input_ready),
    .o_output_data  (o_output_data),
    .o_output_valid (o_output_valid),
    .i_output_ready (i_output_ready)
`ifdef LDPC_SPARSE_BT_ZERO_CHECK_EN
    ,.o_zero_error  (o_zero_error)
`endif
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [W-1:0] rotr7(input logic [W-1:0] x);
    return (x >> 7) | (x << (W - 7));
  endfunction

  function automatic logic [W-1:0] refResult(input logic [W-1:0] words [11]);
    return rotr7(words[0]) ^ words[5];
  endfunction

  function automatic logic [W-1:0] randWord();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s got=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Send beats 0..nbeats-1; push the expected result when the last beat is accepted.
  task automatic applyStimulus(input logic [W-1:0] words [11], input int nbeats,
                               input bit gaps, input bit push, input logic [W-1:0] expected,
                               input bit check_latency, input bit drop, output int stalls);
    int waitc;
    stalls = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge i_clock);
          i_input_valid = 1'b0;
        end
      end
      @(negedge i_clock);
      i_input_valid = 1'b1;
      i_input_data  = words[i];
      waitc = 0;
      while (!o_input_ready && waitc < 500) begin
        @(negedge i_clock);
        waitc++;
        stalls++;
      end
      if (!o_input_ready) begin
        checkOutput("input_ready_timeout", W'(o_input_ready), W'(1));
        i_input_valid = 1'b0;
        return;
      end
      if (push && i == nbeats - 1) exp_q.push_back(expected);
      @(posedge i_clock);
      if (i == watch_beat) begin
        @(negedge i_clock);
        i_input_valid = 1'b0;
`ifdef LDPC_SPARSE_BT_ZERO_CHECK_EN
        checkOutput("zero_error_set", W'(o_zero_error), W'(1));
`endif
      end
    end
    if (check_latency || drop) begin
      @(negedge i_clock);
      i_input_valid = 1'b0;
      if (check_latency) checkOutput("latency_valid", W'(o_output_valid), W'(1));
    end
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || o_output_valid) && c < 3000) begin
      @(negedge i_clock);
      c++;
    end
    checkOutput("drain_pending", W'(exp_q.size()), W'(0));
  endtask

  task automatic doReset();
    @(negedge i_clock);
    i_reset = 1'b1;
    i_input_valid = 1'b0;
    repeat (2) @(negedge i_clock);
    checkOutput("reset_in_ready", W'(o_input_ready), W'(0));
    checkOutput("reset_out_valid", W'(o_output_valid), W'(0));
    checkOutput("reset_out_data", o_output_data, W'(0));
`ifdef LDPC_SPARSE_BT_ZERO_CHECK_EN
    checkOutput("reset_zero_error", W'(o_zero_error), W'(0));
`endif
    i_reset = 1'b0;
  endtask

  // Monitor: chooses output ready, checks holding while stalled, scores handshakes.
  initial begin
    bit held = 0;
    bit rdy;
    logic [W-1:0] held_data = '0;
    forever begin
      @(negedge i_clock);
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b0;
      endcase
      i_output_ready = rdy;
      if (i_reset) begin
        held = 0;
      end else begin
        if (held) begin
          checkOutput("hold_valid", W'(o_output_valid), W'(1));
          checkOutput("hold_data", o_output_data, held_data);
        end
        if (o_output_valid) begin
          if (rdy) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("[TB] FAIL unexpected_output got=%h required=none", o_output_data);
            end else begin
              checkOutput("result", o_output_data, exp_q.pop_front());
            end
            held = 0;
          end else begin
            held = 1;
            held_data = o_output_data;
          end
        end else begin
          held = 0;
        end
      end
    end
  end

  initial begin
    logic [W-1:0] w [11];
    logic [W-1:0] e;
    int stalls, total;

    doReset();

    $display("[TB] directed: 0x80 / 0x2 block");
    ready_mode = 0;
    foreach (w[k]) w[k] = '0;
    w[0] = W'(128);
    w[5] = W'(2);
    applyStimulus(w, 11, 0, 1, W'(3), 1, 1, stalls);
    drain();

    $display("[TB] directed: single bit rotate");
    foreach (w[k]) w[k] = '0;
    w[0] = W'(1);
    e = W'(1) << 89;
    applyStimulus(w, 11, 0, 1, e, 1, 1, stalls);
    drain();

    $display("[TB] back-to-back throughput");
    total = 0;
    for (int b = 0; b < 3; b++) begin
      foreach (w[k]) w[k] = randWord();
      applyStimulus(w, 11, 0, 1, refResult(w), 0, b == 2, stalls);
      total += stalls;
    end
    checkOutput("no_input_bubbles", W'(total), W'(0));
    drain();

    $display("[TB] output held off: stall after two blocks");
    ready_mode = 2;
    foreach (w[k]) w[k] = randWord();
    applyStimulus(w, 11, 0, 1, refResult(w), 1, 1, stalls);
    foreach (w[k]) w[k] = randWord();
    applyStimulus(w, 11, 0, 1, refResult(w), 0, 1, stalls);
    repeat (3) begin
      @(negedge i_clock);
      checkOutput("stall_in_ready", W'(o_input_ready), W'(0));
    end
    foreach (w[k]) w[k] = randWord();
    fork
      applyStimulus(w, 11, 0, 1, refResult(w), 0, 1, stalls);
      begin
        repeat (4) @(negedge i_clock);
        checkOutput("still_stalled", W'(o_input_ready), W'(0));
        ready_mode = 0;
      end
    join
    checkOutput("block3_waited", W'(stalls > 0), W'(1));
    drain();

    $display("[TB] random blocks with random handshakes");
    ready_mode = 1;
    for (int b = 0; b < 100; b++) begin
      foreach (w[k]) w[k] = randWord();
      applyStimulus(w, 11, 1, 1, refResult(w), 0, 1, stalls);
    end
    ready_mode = 0;
    drain();

    $display("[TB] reset mid-block");
    foreach (w[k]) w[k] = randWord();
    applyStimulus(w, 5, 0, 0, '0, 0, 1, stalls);
    doReset();
    foreach (w[k]) w[k] = randWord();
    applyStimulus(w, 11, 0, 1, refResult(w), 1, 1, stalls);
    drain();

`ifdef LDPC_SPARSE_BT_ZERO_CHECK_EN
    $display("[TB] zero check");
    foreach (w[k]) w[k] = '0;
    w[0] = W'(128);
    w[5] = W'(2);
    w[3] = W'(1);
    @(negedge i_clock);
    checkOutput("zero_error_clear", W'(o_zero_error), W'(0));
    watch_beat = 3;
    applyStimulus(w, 11, 0, 1, W'(3), 0, 1, stalls);
    watch_beat = -1;
    drain();
    checkOutput("zero_error_sticky", W'(o_zero_error), W'(1));
    doReset();
`endif

    repeat (3) @(negedge i_clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
